scan_chain_loader: RTL and testbench
====================================

Name: scan_chain_loader

Overview:
- Master end of the instruction-memory scan chain.
- Takes 32-bit words over a valid/ready stream and drives scan_rst_n, scan_en, scan_clk and scan_in toward the memory controller's scan receiver.
- The receiver assembles words LSB-first and writes one word per 32 bits at consecutive addresses.
- Sits beside the memory controller in the SoC top. Its word source is a boot ROM, a debug UART loader or the bench.

Parameters:
WORD_COUNT, 9, number of words per load; matches the receiver's final address + 1.
CLK_DIV, 4, clk cycles per scan_clk period; even, >= 2.

Ports:
clk  in  1  system clock
rst  in  1  reset
start  in  1  begin a load; sampled only in IDLE
word_valid  in  1  word_data holds the next word
word_data  in  32  next word to shift
word_ready  out  1  loader accepts word_data this cycle
scan_clk  out  1  scan clock to receiver
scan_rst_n  out  1  active-low receiver reset
scan_en  out  1  scan enable to receiver
scan_in  out  1  serial data, LSB first
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when a load completes
word_idx  out  $clog2(WORD_COUNT+1)  index of the word being loaded

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
- Reset values of outputs: scan_clk=0, scan_rst_n=1, scan_en=0, scan_in=0, word_ready=0, busy=0, done=0, word_idx=0. Reset values of internal state: state=IDLE, shift register=0, bit counter=0, divider=0.
- All outputs are registered, except word_ready, which is high exactly when state==FETCH.
- States:
  - IDLE: start=1 -> RESET. Clear word_idx.
  - RESET: scan_rst_n=0 for CLK_DIV cycles, then -> FETCH. Raise scan_en in the same edge that scan_rst_n returns to 1.
  - FETCH: word_ready=1, scan_clk=0. On word_valid&word_ready, latch word_data into the shift register, clear the bit counter, then -> SHIFT. With word_valid low, stay in FETCH indefinitely; scan_en stays high and scan_clk stays low.
  - SHIFT: one bit per CLK_DIV cycles.
    - First half-period: scan_clk=0, scan_in=shift[0].
    - Second half-period: scan_clk=1. The rising edge falls mid-bit, so scan_in is stable for CLK_DIV/2 cycles on both sides of it.
    - At the end of each bit: shift right by 1, bit counter +1.
    - After bit 31: if word_idx==WORD_COUNT-1 -> HOLD; else word_idx+1 and -> FETCH.
  - HOLD: scan_clk=0, scan_en=1 for CLK_DIV cycles so the receiver's final combinational imem write completes, then -> DONE.
  - DONE: scan_en=0, done=1 for one cycle, then -> IDLE.
- Exactly 32*WORD_COUNT scan_clk rising edges per load. No scan_clk edges in IDLE, RESET, FETCH, HOLD or DONE.
- Latency with word_valid held high, start sampled at edge T: done is high in cycle T+1+CLK_DIV+WORD_COUNT*(1+32*CLK_DIV)+CLK_DIV. Each FETCH stall cycle adds 1.
- Ignored inputs:
  - start outside IDLE, including during the DONE cycle.
  - word_valid outside FETCH; word_data is not captured.
- Counter widths:
  - bit counter: 5 bits, wraps 31->0 at each word boundary.
  - divider: $clog2(CLK_DIV) bits, reset at every state entry.
  - word_idx: never exceeds WORD_COUNT-1.
- rst mid-load (any state): all outputs return to reset values on the next edge. The next start re-issues the scan_rst_n pulse and reloads from word 0. No partial word is completed.
- start and rst in the same cycle: rst wins.

Test Plan:
1. Default params; start at T; words 0x00000001..0x00000009 with word_valid always high -> 288 scan_clk rises, done high exactly at cycle T+1170, and the receiver-side model captures addr0..8 = 1..9.
2. Single word 0xA5A55A5A -> scan_in sampled at the 32 scan_clk rises reads 0,1,0,1,1,0,1,0,... (LSB first). scan_in never changes within CLK_DIV/2 cycles of a rising edge.
3. Backpressure: word_valid low for 10 cycles before word 3 -> word_ready stays high and scan_clk stays 0 for those 10 cycles, scan_en stays 1, done is delayed to T+1180, and data is unchanged.
4. rst asserted after 17 bits of word 4 -> next cycle all outputs at reset values. A new start gives scan_rst_n low for 4 cycles and word_idx=0, and the full load completes correctly.
5. start pulsed during SHIFT and during the DONE cycle -> no effect: no extra scan_rst_n pulse and busy drops right after DONE. word_valid pulses in SHIFT are not captured.
6. CLK_DIV=2, WORD_COUNT=2 -> scan_clk toggles every cycle in SHIFT, 64 rises, and done at T+1+2+2*65+2 = T+135.

Source files
------------

// File: rtl/scan_chain_loader.sv
// Master end of the instruction-memory scan chain: accepts 32-bit words on a
// valid/ready stream and shifts them LSB-first toward the scan receiver.
module scan_chain_loader #(
  parameter int unsigned WORD_COUNT = 9,
  parameter int unsigned CLK_DIV    = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              word_valid,
  input  logic [31:0]                       word_data,
  output logic                              word_ready,
  output logic                              scan_clk,
  output logic                              scan_rst_n,
  output logic                              scan_en,
  output logic                              scan_in,
  output logic                              busy,
  output logic                              done,
  output logic [$clog2(WORD_COUNT+1)-1:0]   word_idx
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam int unsigned IDX_W = $clog2(WORD_COUNT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_COUNT - 1);

  typedef enum logic [2:0] {
    IDLE,
    RESET,
    FETCH,
    SHIFT,
    HOLD,
    DONE
  } state_t;

  state_t           state;
  logic [31:0]      shift_reg;
  logic [4:0]       bit_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic             div_end;
  logic [DIV_W-1:0] div_inc;

  always_comb begin
    div_end = (div_cnt == DIV_LAST);
    div_inc = div_cnt + 1'b1;
  end

  assign word_ready = (state == FETCH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      div_cnt    <= '0;
      word_idx   <= '0;
      scan_clk   <= 1'b0;
      scan_rst_n <= 1'b1;
      scan_en    <= 1'b0;
      scan_in    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state      <= RESET;
            div_cnt    <= '0;
            word_idx   <= '0;
            scan_rst_n <= 1'b0;
            busy       <= 1'b1;
          end
        end

        RESET: begin
          if (div_end) begin
            state      <= FETCH;
            div_cnt    <= '0;
            scan_rst_n <= 1'b1;
            scan_en    <= 1'b1;
          end else begin
            div_cnt <= div_inc;
          end
        end

        FETCH: begin
          scan_clk <= 1'b0;
          if (word_valid) begin
            state     <= SHIFT;
            shift_reg <= word_data;
            bit_cnt   <= '0;
            div_cnt   <= '0;
            scan_in   <= word_data[0];
          end
        end

        SHIFT: begin
          if (div_end) begin
            // scan_in advances only here, half a scan_clk period after the rise
            shift_reg <= {1'b0, shift_reg[31:1]};
            bit_cnt   <= bit_cnt + 1'b1;
            div_cnt   <= '0;
            scan_clk  <= 1'b0;
            scan_in   <= shift_reg[1];
            if (bit_cnt == 5'd31) begin
              if (word_idx == IDX_LAST) begin
                state <= HOLD;
              end else begin
                word_idx <= word_idx + 1'b1;
                state    <= FETCH;
              end
            end
          end else begin
            div_cnt  <= div_inc;
            scan_clk <= (div_inc >= DIV_HALF);
            scan_in  <= shift_reg[0];
          end
        end

        HOLD: begin
          scan_clk <= 1'b0;
          if (div_end) begin
            state   <= DONE;
            div_cnt <= '0;
            scan_en <= 1'b0;
            done    <= 1'b1;
          end else begin
            div_cnt <= div_inc;
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_chain_loader.sv
// Directed bench for scan_chain_loader: default instance plus a CLK_DIV=2,
// WORD_COUNT=2 instance, each with a receiver-side model of the scan chain.
module tb_scan_chain_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, word_valid, word_ready;
  logic [31:0] word_data;
  logic        scan_clk, scan_rst_n, scan_en, scan_in, busy, done;
  logic [3:0]  word_idx;

  logic        start2, word_valid2, word_ready2;
  logic [31:0] word_data2;
  logic        scan_clk2, scan_rst_n2, scan_en2, scan_in2, busy2, done2;
  logic [1:0]  word_idx2;

  scan_chain_loader u_dut (
    .clk(clk), .rst(rst), .start(start), .word_valid(word_valid),
    .word_data(word_data), .word_ready(word_ready), .scan_clk(scan_clk),
    .scan_rst_n(scan_rst_n), .scan_en(scan_en), .scan_in(scan_in),
    .busy(busy), .done(done), .word_idx(word_idx)
  );

  scan_chain_loader #(.WORD_COUNT(2), .CLK_DIV(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .word_valid(word_valid2),
    .word_data(word_data2), .word_ready(word_ready2), .scan_clk(scan_clk2),
    .scan_rst_n(scan_rst_n2), .scan_en(scan_en2), .scan_in(scan_in2),
    .busy(busy2), .done(done2), .word_idx(word_idx2)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // word sources
  logic [31:0] words [0:8];
  logic [31:0] words2 [0:1];
  int   ptr = 0, ptr2 = 0;
  logic ptr_clr = 1'b0, ptr2_clr = 1'b0;
  logic feed_valid = 1'b0, glitch = 1'b0, feed_valid2 = 1'b0;

  always @(posedge clk) begin
    if (ptr_clr) ptr <= 0;
    else if (word_valid && word_ready) ptr <= ptr + 1;
    if (ptr2_clr) ptr2 <= 0;
    else if (word_valid2 && word_ready2) ptr2 <= ptr2 + 1;
  end

  assign word_valid  = feed_valid | glitch;
  assign word_data   = glitch ? 32'hDEADBEEF : ((ptr < 9) ? words[ptr] : 32'h0);
  assign word_valid2 = feed_valid2;
  assign word_data2  = (ptr2 < 2) ? words2[ptr2] : 32'h0;

  // receiver model: LSB-first assembly, one word per 32 scan_clk rises
  logic [31:0] rx_mem [0:8];
  logic [31:0] rx_sr, bit_log;
  int rx_addr = 0, rx_bits = 0, rises = 0, rst_pulses = 0;
  always @(posedge scan_clk or negedge scan_rst_n) begin
    if (!scan_rst_n) begin
      rst_pulses++;
      rx_addr = 0;
      rx_bits = 0;
      for (int i = 0; i < 9; i++) rx_mem[i] = '0;
    end else begin
      rises++;
      if (scan_en) begin
        rx_sr = {scan_in, rx_sr[31:1]};
        if (rx_addr == 0) bit_log[rx_bits] = scan_in;
        rx_bits++;
        if (rx_bits == 32) begin
          if (rx_addr < 9) rx_mem[rx_addr] = rx_sr;
          rx_addr++;
          rx_bits = 0;
        end
      end
    end
  end

  logic [31:0] rx2_mem [0:1];
  logic [31:0] rx2_sr;
  int rx2_addr = 0, rx2_bits = 0, rises2 = 0;
  always @(posedge scan_clk2 or negedge scan_rst_n2) begin
    if (!scan_rst_n2) begin
      rx2_addr = 0;
      rx2_bits = 0;
      rx2_mem[0] = '0;
      rx2_mem[1] = '0;
    end else begin
      rises2++;
      if (scan_en2) begin
        rx2_sr = {scan_in2, rx2_sr[31:1]};
        rx2_bits++;
        if (rx2_bits == 32) begin
          if (rx2_addr < 2) rx2_mem[rx2_addr] = rx2_sr;
          rx2_addr++;
          rx2_bits = 0;
        end
      end
    end
  end

  // scan_in must not move within 2 clk cycles of a scan_clk rise (dut1)
  int   last_rise = -100, last_chg = -100, viol = 0, toggles2 = 0;
  logic prev_sclk = 1'b0, prev_sin = 1'b0, prev_sclk2 = 1'b0;
  always @(negedge clk) begin
    if (scan_clk === 1'b1 && prev_sclk === 1'b0) begin
      if (cyc - last_chg < 2) viol++;
      last_rise = cyc;
    end
    if (scan_in !== prev_sin) begin
      if (cyc - last_rise < 2) viol++;
      last_chg = cyc;
    end
    prev_sclk = scan_clk;
    prev_sin  = scan_in;
    if (scan_clk2 !== prev_sclk2) toggles2++;
    prev_sclk2 = scan_clk2;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // start is sampled at the returned edge number t
  task automatic start_load(input int sel, output int t);
    @(negedge clk);
    if (sel == 1) begin ptr_clr = 1'b1; start = 1'b1; end
    else begin ptr2_clr = 1'b1; start2 = 1'b1; end
    t = cyc + 1;
    @(negedge clk);
    ptr_clr = 1'b0; start = 1'b0; ptr2_clr = 1'b0; start2 = 1'b0;
  endtask

  // done must first appear in the period following edge exp_edge
  task automatic wait_done(input int sel, input int exp_edge, input bit pulse_start);
    int seen = -1;
    for (int n = 0; n < 3000; n++) begin
      if ((sel == 1 ? done : done2) === 1'b1) begin
        seen = cyc;
        break;
      end
      @(negedge clk);
    end
    chk("done_edge", seen, exp_edge);
    chk("done_busy", 32'(sel == 1 ? busy : busy2), 1);
    chk("done_scan_en", 32'(sel == 1 ? scan_en : scan_en2), 0);
    if (pulse_start) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_one_cycle", 32'(sel == 1 ? done : done2), 0);
    chk("idle_busy", 32'(sel == 1 ? busy : busy2), 0);
    if (pulse_start) begin
      @(negedge clk);
      chk("start_in_done_busy", 32'(busy), 0);
      chk("start_in_done_rst_n", 32'(scan_rst_n), 1);
    end
  endtask

  task automatic wait_ptr(input int target);
    for (int n = 0; n < 2000 && ptr != target; n++) @(negedge clk);
    chk("ptr_reach", ptr, target);
  endtask

  task automatic chk_rx(input logic [31:0] base);
    for (int i = 0; i < 9; i++) chk("rx_word", rx_mem[i], base + 32'(i));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_scan_clk"}, 32'(scan_clk), 0);
    chk({tag, "_scan_rst_n"}, 32'(scan_rst_n), 1);
    chk({tag, "_scan_en"}, 32'(scan_en), 0);
    chk({tag, "_scan_in"}, 32'(scan_in), 0);
    chk({tag, "_word_ready"}, 32'(word_ready), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_word_idx"}, 32'(word_idx), 0);
  endtask

  int t, r0, p0, tg0;
  int exp_b [8] = '{0, 1, 0, 1, 1, 0, 1, 0};

  initial begin
    rst = 1'b1; start = 1'b0; start2 = 1'b0;
    for (int i = 0; i < 9; i++) words[i] = '0;
    words2[0] = '0; words2[1] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("reset");
    chk("reset_busy2", 32'(busy2), 0);
    chk("reset_done2", 32'(done2), 0);

    // words 1..9, valid always high: 1+4+9*129+4 = 1170 -> done after edge t+1169
    for (int i = 0; i < 9; i++) words[i] = 32'(i + 1);
    feed_valid = 1'b1;
    r0 = rises; p0 = rst_pulses;
    start_load(1, t);
    wait_done(1, t + 1169, 1'b0);
    chk("t1_rises", rises - r0, 288);
    chk("t1_rst_pulses", rst_pulses - p0, 1);
    chk_rx(32'h1);

    // LSB-first order of 0xA5A55A5A
    words[0] = 32'hA5A55A5A;
    for (int i = 1; i < 9; i++) words[i] = 32'h1000_0000 + 32'(i);
    start_load(1, t);
    wait_done(1, t + 1169, 1'b0);
    for (int i = 0; i < 8; i++) chk("t2_bit", 32'(bit_log[i]), exp_b[i]);
    chk("t2_word0", rx_mem[0], 32'hA5A55A5A);
    chk("t2_word8", rx_mem[8], 32'h1000_0008);
    chk("t2_scan_in_stable", viol, 0);

    // backpressure: 10 stall cycles in FETCH before word 3
    for (int i = 0; i < 9; i++) words[i] = 32'h3000_0000 + 32'(i);
    start_load(1, t);
    wait_ptr(3);
    feed_valid = 1'b0;
    for (int n = 0; n < 400 && word_ready !== 1'b1; n++) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk("stall_ready", 32'(word_ready), 1);
      chk("stall_scan_clk", 32'(scan_clk), 0);
      chk("stall_scan_en", 32'(scan_en), 1);
      @(negedge clk);
    end
    feed_valid = 1'b1;
    wait_done(1, t + 1179, 1'b0);
    chk_rx(32'h3000_0000);

    // rst after 17 bits of word 4, then a clean reload
    for (int i = 0; i < 9; i++) words[i] = 32'hC0DE_0000 + 32'(i);
    start_load(1, t);
    wait_ptr(5);
    repeat (68) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("midrst");
    for (int i = 0; i < 9; i++) words[i] = 32'h4000_0100 + 32'(i);
    r0 = rises; p0 = rst_pulses;
    start_load(1, t);
    chk("t4_word_idx", 32'(word_idx), 0);
    for (int i = 0; i < 4; i++) begin
      chk("t4_rst_n_low", 32'(scan_rst_n), 0);
      @(negedge clk);
    end
    chk("t4_rst_n_high", 32'(scan_rst_n), 1);
    chk("t4_scan_en", 32'(scan_en), 1);
    wait_done(1, t + 1169, 1'b0);
    chk("t4_rises", rises - r0, 288);
    chk("t4_rst_pulses", rst_pulses - p0, 1);
    chk_rx(32'h4000_0100);

    // start and word_valid pulses while shifting, start during DONE
    for (int i = 0; i < 9; i++) words[i] = 32'h5000_0000 + 32'(i);
    p0 = rst_pulses;
    start_load(1, t);
    wait_ptr(1);
    feed_valid = 1'b0;
    repeat (10) @(negedge clk);
    start = 1'b1; glitch = 1'b1;
    @(negedge clk);
    start = 1'b0; glitch = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_word_idx", 32'(word_idx), 0);
    chk("t5_scan_rst_n", 32'(scan_rst_n), 1);
    feed_valid = 1'b1;
    wait_done(1, t + 1169, 1'b1);
    chk("t5_rst_pulses", rst_pulses - p0, 1);
    chk_rx(32'h5000_0000);

    // CLK_DIV=2, WORD_COUNT=2: 1+2+2*65+2 = 135 -> done after edge t+134
    words2[0] = 32'h6000_000F;
    words2[1] = 32'hF0F0_1234;
    feed_valid2 = 1'b1;
    r0 = rises2; tg0 = toggles2;
    start_load(2, t);
    wait_done(2, t + 134, 1'b0);
    chk("t6_rises", rises2 - r0, 64);
    chk("t6_toggles", toggles2 - tg0, 128);
    chk("t6_word0", rx2_mem[0], 32'h6000_000F);
    chk("t6_word1", rx2_mem[1], 32'hF0F0_1234);

    repeat (4) @(negedge clk);
    chk("final_scan_in_stable", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
